// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Glyph codes, load modes and glyph-to-segment decode for the
//            seven-segment display controller.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [4:0] glyph_t;

    localparam glyph_t G_L    = 5'd16;
    localparam glyph_t G_N    = 5'd17;
    localparam glyph_t G_P    = 5'd18;
    localparam glyph_t G_R    = 5'd19;
    localparam glyph_t G_S    = 5'd20;
    localparam glyph_t G_U    = 5'd21;
    localparam glyph_t G_Y    = 5'd22;
    localparam glyph_t G_DASH = 5'd23;
    localparam glyph_t G_DARK = 5'd31;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic [1:0] {
        MODE_HEX   = 2'd0,
        MODE_DEC   = 2'd1,
        MODE_GLYPH = 2'd2,
        MODE_BLANK = 2'd3
    } mode_t;

    // Active-low, bit order {g,f,e,d,c,b,a}; unassigned codes stay dark.
    function automatic logic [6:0] glyph_to_seg(input glyph_t g);
        logic [6:0] seg;
        case (g)
            5'd0:    seg = 7'b1000000;
            5'd1:    seg = 7'b1111001;
            5'd2:    seg = 7'b0100100;
            5'd3:    seg = 7'b0110000;
            5'd4:    seg = 7'b0011001;
            5'd5:    seg = 7'b0010010;
            5'd6:    seg = 7'b0000010;
            5'd7:    seg = 7'b1111000;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0010000;
            5'd10:   seg = 7'b0001000;
            5'd11:   seg = 7'b0000011;
            5'd12:   seg = 7'b1000110;
            5'd13:   seg = 7'b0100001;
            5'd14:   seg = 7'b0000110;
            5'd15:   seg = 7'b0001110;
            G_L:     seg = 7'b1000111;
            G_N:     seg = 7'b0101011;
            G_P:     seg = 7'b0001100;
            G_R:     seg = 7'b0101111;
            G_S:     seg = 7'b0010010;
            G_U:     seg = 7'b1000001;
            G_Y:     seg = 7'b0011001;
            G_DASH:  seg = 7'b0111111;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential double-dabble converter, one shift per clock.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int VALUE_W    = 16,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [VALUE_W-1:0]      i_bin,
    output logic                    o_done,
    output logic [NUM_DIGITS*4-1:0] o_bcd,
    output logic                    o_ovf
);

    localparam int BCD_W = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    logic [VALUE_W-1:0] r_shift;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_active;
    logic               r_done;
    logic               r_ovf;

    logic [BCD_W-1:0]   w_src;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_next;
    logic               w_bit;
    logic               w_out;

    // The start cycle already performs the first shift from a zero BCD field,
    // so the final shift lands VALUE_W edges after i_start.
    always_comb begin
        w_src = i_start ? '0 : r_bcd;
        w_bit = i_start ? i_bin[VALUE_W-1] : r_shift[VALUE_W-1];
        w_adj = w_src;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_src[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = w_src[4*k +: 4] + 4'd3;
            end
        end
        w_next = {w_adj[BCD_W-2:0], w_bit};
        w_out  = w_adj[BCD_W-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift  <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_bcd    <= w_next;
                r_shift  <= i_bin << 1;
                r_ovf    <= w_out;
                r_cnt    <= CNT_W'(VALUE_W - 1);
                r_active <= (VALUE_W > 1);
                r_done   <= (VALUE_W == 1);
            end else if (r_active) begin
                r_bcd   <= w_next;
                r_shift <= r_shift << 1;
                r_ovf   <= r_ovf | w_out;
                r_cnt   <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_bcd;
    assign o_ovf  = r_ovf;

endmodule
`default_nettype wire

// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_display_ctrl
// Brief    : Buffered multi-digit seven-segment controller with HEX/DEC/GLYPH
//            loads, leading-zero blanking and per-digit blinking.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int VALUE_W    = 16,
    parameter int BLINK_DIV  = 12_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [1:0]              i_mode,
    input  logic [VALUE_W-1:0]      i_value,
    input  logic [NUM_DIGITS*5-1:0] i_glyphs,
    input  logic                    i_lzb,
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
    output logic                    o_busy,
    output logic [NUM_DIGITS*7-1:0] o_seg
);

    localparam int BCD_W = NUM_DIGITS * 4;
    localparam int PAD_W = (BCD_W > VALUE_W) ? BCD_W : VALUE_W;
    localparam int BLK_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [NUM_DIGITS*5-1:0] r_buf;
    logic [NUM_DIGITS*5-1:0] w_buf_next;
    logic                    r_lzb;
    logic [BLK_W-1:0]        r_blink_cnt;
    logic                    r_phase;
    logic [NUM_DIGITS*7-1:0] r_seg;
    logic [NUM_DIGITS*7-1:0] w_seg;

    logic                    w_accept;
    logic                    w_start;
    logic                    w_done;
    logic                    w_ovf;
    logic [BCD_W-1:0]        w_bcd;
    logic [PAD_W-1:0]        w_value_ext;
    logic [BCD_W-1:0]        w_hex;

    assign w_value_ext = PAD_W'(i_value);
    assign w_hex       = w_value_ext[BCD_W-1:0];

    // Zero digits above the most significant non-zero one go dark; digit 0 never does.
    function automatic logic [NUM_DIGITS*5-1:0] nibbles_to_glyphs(
        input logic [BCD_W-1:0] nibs,
        input logic             lzb
    );
        logic [NUM_DIGITS*5-1:0] g;
        logic                    leading;
        leading = lzb;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (leading && (k != 0) && (nibs[4*k +: 4] == 4'd0)) begin
                g[5*k +: 5] = G_DARK;
            end else begin
                g[5*k +: 5] = {1'b0, nibs[4*k +: 4]};
                leading     = 1'b0;
            end
        end
        return g;
    endfunction

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_start),
        .i_bin   (i_value),
        .o_done  (w_done),
        .o_bcd   (w_bcd),
        .o_ovf   (w_ovf)
    );

    always_comb begin
        w_accept     = i_load && (r_state == ST_IDLE);
        w_start      = w_accept && (mode_t'(i_mode) == MODE_DEC);
        w_state_next = r_state;
        w_buf_next   = r_buf;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (mode_t'(i_mode))
                        MODE_HEX:   w_buf_next   = nibbles_to_glyphs(w_hex, i_lzb);
                        MODE_DEC:   w_state_next = ST_CONVERT;
                        MODE_GLYPH: w_buf_next   = i_glyphs;
                        MODE_BLANK: w_buf_next   = {NUM_DIGITS{G_DARK}};
                        default:    w_buf_next   = r_buf;
                    endcase
                end
            end
            // Buffer is written on entry to COMMIT so the new digits reach
            // o_seg on the same edge that drops o_busy.
            ST_CONVERT: begin
                if (w_done) begin
                    w_state_next = ST_COMMIT;
                    w_buf_next   = w_ovf ? {NUM_DIGITS{G_DASH}}
                                         : nibbles_to_glyphs(w_bcd, r_lzb);
                end
            end
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_buf       <= {NUM_DIGITS{G_DARK}};
            r_lzb       <= 1'b0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_seg       <= '1;
        end else begin
            r_state <= w_state_next;
            r_buf   <= w_buf_next;
            if (w_start) begin
                r_lzb <= i_lzb;
            end
            if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end
            r_seg <= w_seg;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        assign w_seg[7*k +: 7] = glyph_to_seg((r_phase && i_blink_mask[k]) ? G_DARK
                                                                           : r_buf[5*k +: 5]);
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_seg  = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_display_ctrl
// Brief    : Scoreboard bench driving an 8-digit and a 4-digit controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_display_ctrl;

    localparam int VW = 16;
    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [1:0]  mode;
    logic [VW-1:0] value;
    logic [39:0] glyphs;
    logic        lzb;
    logic [7:0]  mask;
    logic        busy8, busy4;
    logic [55:0] seg8;
    logic [27:0] seg4;

    always #5 clk = ~clk;

    seg7_display_ctrl #(.NUM_DIGITS(8), .VALUE_W(VW), .BLINK_DIV(BD)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_mode(mode), .i_value(value),
        .i_glyphs(glyphs), .i_lzb(lzb), .i_blink_mask(mask),
        .o_busy(busy8), .o_seg(seg8));

    seg7_display_ctrl #(.NUM_DIGITS(4), .VALUE_W(VW), .BLINK_DIV(BD)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_mode(mode), .i_value(value),
        .i_glyphs(glyphs[19:0]), .i_lzb(lzb), .i_blink_mask(mask[3:0]),
        .o_busy(busy4), .o_seg(seg4));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          apply;
        logic [39:0] g8;
        logic [39:0] g4;
    } upd_t;
    upd_t sbq[$];

    int busy_from = -10;
    int busy_to   = -10;

    function automatic bit busy_at(int t);
        return (t >= busy_from) && (t <= busy_to);
    endfunction

    function automatic logic [6:0] seg_of(int code);
        case (code)
            0:  return 7'b1000000;  1:  return 7'b1111001;
            2:  return 7'b0100100;  3:  return 7'b0110000;
            4:  return 7'b0011001;  5:  return 7'b0010010;
            6:  return 7'b0000010;  7:  return 7'b1111000;
            8:  return 7'b0000000;  9:  return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  15: return 7'b0001110;
            16: return 7'b1000111;  17: return 7'b0101011;
            18: return 7'b0001100;  19: return 7'b0101111;
            20: return 7'b0010010;  21: return 7'b1000001;
            22: return 7'b0011001;  23: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected glyph buffer of an n-digit display after a load.
    function automatic logic [39:0] model_glyphs(int n, int md, int val, logic [39:0] gl, bit lz);
        logic [39:0] g;
        int d[8];
        int p10;
        int hi;
        g = {8{5'd31}};
        if (md == 3) return g;
        if (md == 2) begin
            for (int k = 0; k < n; k++) g[5*k +: 5] = gl[5*k +: 5];
            return g;
        end
        p10 = 1;
        for (int k = 0; k < n; k++) p10 = p10 * 10;
        if (md == 1 && val >= p10) begin
            for (int k = 0; k < n; k++) g[5*k +: 5] = 5'd23;
            return g;
        end
        p10 = 1;
        for (int k = 0; k < n; k++) begin
            d[k] = (md == 0) ? ((val >> (4*k)) & 15) : ((val / p10) % 10);
            p10  = p10 * 10;
        end
        hi = 0;
        for (int k = 0; k < n; k++) if (d[k] != 0) hi = k;
        for (int k = 0; k < n; k++) g[5*k +: 5] = (lz && k > hi) ? 5'd31 : 5'(d[k]);
        return g;
    endfunction

    function automatic logic [55:0] model_seg(int n, logic [39:0] g, logic [7:0] m, bit ph);
        logic [55:0] s;
        s = '1;
        for (int k = 0; k < n; k++)
            s[7*k +: 7] = seg_of((ph && m[k]) ? 31 : int'(g[5*k +: 5]));
        return s;
    endfunction

    task automatic check(input string name, input logic [55:0] act, input logic [55:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // Monitor: expected outputs for the next cycle come from the model buffer
    // (updated by popping scoreboard entries) and the blink phase, which is a
    // pure function of edges elapsed since reset.
    logic [39:0] cur8, cur4;
    logic [55:0] exp8, exp4, tmp;
    int          m_edges = 0;
    bit          started = 0;
    bit          ph;

    always @(negedge clk) begin
        if (started) begin
            check("seg8", seg8, exp8);
            check("seg4", 56'(seg4), exp4);
            check("busy8", 56'(busy8), 56'(busy_at(cyc)));
            check("busy4", 56'(busy4), 56'(busy_at(cyc)));
        end
        if (rst) begin
            started = 1;
            sbq.delete();
            cur8    = {8{5'd31}};
            cur4    = {8{5'd31}};
            exp8    = '1;
            exp4    = {28'h0, 28'hFFFFFFF};
            m_edges = 0;
        end else if (started) begin
            while (sbq.size() > 0 && sbq[0].apply <= cyc) begin
                cur8 = sbq[0].g8;
                cur4 = sbq[0].g4;
                void'(sbq.pop_front());
            end
            ph   = ((m_edges / BD) % 2) == 1;
            exp8 = model_seg(8, cur8, mask, ph);
            tmp  = model_seg(4, cur4, mask, ph);
            exp4 = {28'h0, tmp[27:0]};
            m_edges++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(int md, int val, logic [39:0] gl, bit lz);
        upd_t u;
        mode   = md[1:0];
        value  = val[VW-1:0];
        glyphs = gl;
        lzb    = lz;
        load   = 1'b1;
        if (!busy_at(cyc)) begin
            u.g8    = model_glyphs(8, md, val, gl, lz);
            u.g4    = model_glyphs(4, md, val, gl, lz);
            u.apply = (md == 1) ? cyc + VW + 1 : cyc + 1;
            sbq.push_back(u);
            if (md == 1) begin
                busy_from = cyc + 1;
                busy_to   = cyc + VW + 1;
            end
        end
        tick();
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if (busy_to > cyc) busy_to = cyc;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy_at(cyc); i++) tick();
    endtask

    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S_DASH = 7'b0111111;

    logic [63:0] rnd64;
    int          bc;
    int          dark_cnt;

    initial begin
        rst = 1'b1; load = 1'b0; mode = 2'd0; value = '0; glyphs = '1; lzb = 1'b0; mask = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_seg8", seg8, '1);

        // HEX 1A3F without blanking
        do_load(0, 'h1A3F, '1, 0);
        tick();
        check("hex_seg8", seg8, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                                 7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110});
        check("hex_busy", 56'(busy8), 56'(0));

        // DEC 12345 with blanking: busy for 17 cycles, result at cycle 18
        wait_idle();
        do_load(1, 12345, '1, 1);
        bc = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy8) bc++;
            if (i == 18) begin
                check("dec_seg8", seg8, {S_OFF, S_OFF, S_OFF, 7'b1111001, 7'b0100100,
                                         7'b0110000, 7'b0011001, 7'b0010010});
                check("dec_ovf_seg4", 56'(seg4), 56'({4{S_DASH}}));
            end
            tick();
        end
        check("dec_busy_len", 56'(bc), 56'(17));

        // 4-digit overflow boundary and blanked zero
        do_load(1, 10000, '1, 0);
        repeat (17) tick();
        check("ovf_seg4", 56'(seg4), 56'({4{S_DASH}}));
        wait_idle();
        do_load(1, 0, '1, 1);
        repeat (17) tick();
        check("zero_seg4", 56'(seg4), 56'({S_OFF, S_OFF, S_OFF, 7'b1000000}));

        // GLYPH "PLAY" on digits 7..4
        wait_idle();
        do_load(2, 0, {5'd18, 5'd16, 5'd10, 5'd22, 5'd31, 5'd31, 5'd31, 5'd31}, 0);
        tick();
        check("glyph_hi", 56'(seg8[55:28]),
              56'({7'b0001100, 7'b1000111, 7'b0001000, 7'b0011001}));
        check("glyph_lo", 56'(seg8[27:0]), 56'(28'hFFFFFFF));

        // Blink digits 1..0; a reload mid-window must not shift the phase
        do_load(0, 'h1A3F, '1, 0);
        mask = 8'h03;
        tick();
        dark_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (seg8[13:0] == 14'h3FFF) dark_cnt++;
            if (i == 5) do_load(0, 'h1A3F, '1, 0);
            else tick();
        end
        check("blink_dark_cycles", 56'(dark_cnt), 56'(8));
        mask = 8'h00;

        // DEC load, ignored second load, reset mid-conversion
        tick();
        wait_idle();
        do_load(1, 4321, '1, 0);
        repeat (4) tick();
        do_load(0, 'hBEEF, '1, 0);
        repeat (2) tick();
        do_reset();
        check("rst_busy", 56'(busy8), 56'(0));
        check("rst_seg8", seg8, '1);
        do_load(0, 'h00C5, '1, 1);
        tick();
        check("post_rst_hex", seg8, {S_OFF, S_OFF, S_OFF, S_OFF, S_OFF, S_OFF,
                                     7'b1000110, 7'b0010010});

        // Randomized traffic
        for (int it = 0; it < 250; it++) begin
            int md;
            int val;
            md  = $urandom_range(0, 3);
            val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 65535);
            rnd64 = {$urandom(), $urandom()};
            if ($urandom_range(0, 5) == 0) mask = 8'($urandom());
            if ($urandom_range(0, 49) == 0) do_reset();
            else do_load(md, val, rnd64[39:0], 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 20)) tick();
        end

        wait_idle();
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
Parametrised multi-digit seven-segment display controller. It replaces per-state hard-coded digit tables with a registered display buffer. The buffer loads from a hex value, a binary value converted sequentially to decimal, or a per-digit glyph string. It also provides per-digit blinking and leading-zero blanking. It sits between the top-level FSMs (player, recorder, init) and the board HEX pins.

Parameters:
NUM_DIGITS, 8, number of seven-segment digits driven (1..8)
VALUE_W, 16, width of the numeric input value
BLINK_DIV, 12_000_000, i_clk cycles per blink half-period (>=2)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_load  input  1  single-cycle load strobe; accepted only when o_busy=0
i_mode  input  2  0=HEX, 1=DEC, 2=GLYPH, 3=BLANK; sampled with i_load
i_value  input  VALUE_W  numeric value for HEX/DEC; sampled with i_load
i_glyphs  input  NUM_DIGITS*5  5-bit glyph code per digit, digit 0 in bits [4:0]; sampled with i_load
i_lzb  input  1  leading-zero blanking enable for HEX/DEC; sampled with i_load
i_blink_mask  input  NUM_DIGITS  per-digit blink enable; live, not latched
o_busy  output  1  decimal conversion in progress
o_seg  output  NUM_DIGITS*7  active-low segments; digit k in [7k+6:7k]; bit0=top, 1=upper-right, 2=lower-right, 3=bottom, 4=lower-left, 5=upper-left, 6=middle

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset: all o_seg bits 1 (every digit dark). o_busy=0. Display buffer set to DARK glyphs. Blink counter=0, blink phase=0. Any conversion in progress is aborted.
- Display buffer: NUM_DIGITS 5-bit glyph codes. o_seg is registered and is decoded from the buffer and the blink phase.
- Glyph codes (package): 0-15 = hex 0-F; 16=L, 17=N, 18=P, 19=R, 20=S, 21=U, 22=Y, 23=dash (middle segment only), 31=DARK; 24-30 decode as DARK.
- Ignored loads: i_load while o_busy=1 is ignored, with no queueing.
- HEX mode: digit k = i_value[4k+3:4k]. Nibbles beyond VALUE_W are zero. Buffer updates on the edge after i_load. o_seg reflects the new content 2 cycles after i_load. o_busy stays 0.
- GLYPH mode: same timing as HEX. The buffer takes i_glyphs directly.
- BLANK mode: same timing. All digits are set to DARK.
- DEC mode: conversion sequence.
  - o_busy rises on the edge after i_load.
  - A double-dabble engine performs VALUE_W shift cycles (add-3 on each BCD nibble >=5, then shift).
  - A sticky overflow flag sets if a 1 shifts out of the top BCD digit.
  - Commit cycle follows the shifts: buffer written and o_busy cleared. o_busy is high for exactly VALUE_W+1 cycles.
  - o_seg shows the result VALUE_W+2 cycles after i_load.
  - If overflow is set (value >= 10^NUM_DIGITS), every digit shows dash.
- Leading-zero blanking (HEX/DEC, i_lzb=1): zero digits above the most significant non-zero digit become DARK. Digit 0 is never blanked. Blanking is applied at commit. It does not apply to GLYPH mode or to the overflow pattern.
- Blink: a free-running counter counts 0..BLINK_DIV-1. On wrap the phase toggles. While phase=1, digits with i_blink_mask[k]=1 output DARK. Mask changes take effect on the next o_seg register update (1 cycle).
- Buffer persistence: the buffer holds its content indefinitely between loads. A load never disturbs the blink counter.
- Reset during DEC conversion: o_busy=0 the next cycle and the display goes dark. A new load is accepted the cycle after i_rst deasserts.
- Simultaneous i_load and commit: o_busy=1 in that cycle, so the load is ignored.

Decomposition:
- Package seg7_pkg:
  - glyph_t (5-bit) and glyph code localparams (G_L, G_N, G_P, G_R, G_S, G_U, G_Y, G_DASH, G_DARK).
  - mode_t enum (MODE_HEX, MODE_DEC, MODE_GLYPH, MODE_BLANK).
  - Function glyph_to_seg(glyph_t) returning the 7-bit active-low pattern.
- Sub-module bin2bcd_seq (params VALUE_W, NUM_DIGITS):
  - Ports: i_clk, i_rst, i_start, i_bin, o_done (1-cycle), o_bcd, o_ovf.
  - Owns the shift counter and the add-3 logic.
  - The top module holds the mode FSM (IDLE, CONVERT, COMMIT), the buffer, blanking, blink and the output register.

Test Plan:
1. Reset, then HEX load i_value=16'h1A3F, i_lzb=0, NUM_DIGITS=8 -> 2 cycles later digits 7..0 = 0,0,0,0,1,A,3,F; o_busy never rises.
2. DEC load i_value=12345, i_lzb=1 -> o_busy high exactly 17 cycles; at cycle 18 digits 4..0 = 1,2,3,4,5 and digits 7..5 dark.
3. NUM_DIGITS=4, DEC load i_value=16'd10000 -> all 4 digits dash; DEC load 0 with i_lzb=1 -> digit 0 shows 0, others dark.
4. GLYPH load "P,L,A,Y" codes 18,16,10,22 on digits 7..4, DARK elsewhere -> o_seg[55:28] = 0001100, 1000111, 0001000, 0011001 (digits 7..4).
5. BLINK_DIV=4, i_blink_mask=8'h03 -> digits 1..0 alternate pattern/dark every 4 cycles; other digits steady; i_load during a dark phase leaves phase timing unchanged.
6. Assert i_load in DEC mode, a second i_load at busy cycle 5 (ignored), i_rst at cycle 8 -> o_busy=0 and all dark next cycle; a HEX load afterwards displays normally.
